clk_26_monitor: RTL and testbench
=================================

// Module: clk_26_monitor
// PURPOSE
//  Receive-side checker for the divided pixel clock (nominal ref_clock/10, 50% duty).
//  Samples the clock in the ref_clock domain and emits single-cycle rise/fall strobes.
//  Measures every half-period in ref_clock cycles and tracks frequency lock.
//  Flags a stopped or off-frequency clock so downstream video logic can hold off.
// PARAMETERS
//  DIV_HALF    5   expected half-period in ref_clock cycles
//  TOL         1   accepted deviation: |meas - DIV_HALF| <= TOL is a good edge
//  LOCK_COUNT  8   consecutive good edges needed to enter LOCKED
//  TIMEOUT     20  ref_clock cycles without an edge before the clock is declared missing
//  CNT_W       8   width of half-period counter/measurement (must hold TIMEOUT)
// PORTS
//  ref_clock    in   1      system reference clock
//  reset        in   1      asynchronous, active-high
//  clk_in       in   1      monitored clock, asynchronous to ref_clock
//  en           in   1      monitor enable; low forces UNLOCKED
//  rise_strobe  out  1      one-cycle pulse per detected rising edge of clk_in
//  fall_strobe  out  1      one-cycle pulse per detected falling edge of clk_in
//  half_period  out  CNT_W  last measured half-period, in ref_clock cycles
//  locked       out  1      high while in LOCKED state
//  lock_lost    out  1      one-cycle pulse on any LOCKED->UNLOCKED exit
//  clk_missing  out  1      high from timeout until the next edge
//  err_count    out  16     saturating count of lock losses
// BEHAVIOUR
//  Reset: every output and all internal state are 0; the FSM is UNLOCKED.
//  Input path: 2-flop synchronizer, then a history flop. Edge = sync2 != hist.
//  Strobes are registered. Latency is 3 ref_clock cycles from the clk_in transition.
//  Counter cnt: set to 1 on an edge cycle, else increments. It saturates at 2^CNT_W-1.
//  On an edge cycle: meas = cnt (value before reload). half_period <= meas.
//  Nominal div-10 input gives meas = 5.
//  good = (meas >= DIV_HALF-TOL) && (meas <= DIV_HALF+TOL). Compare unsigned; no underflow.
//  FSM:
//   UNLOCKED: first edge -> ACQUIRE. That measurement is discarded. good_cnt <= 0.
//   ACQUIRE: good edge -> good_cnt++. Bad edge -> good_cnt <= 0.
//    When good_cnt reaches LOCK_COUNT -> LOCKED. locked rises in the same cycle as the state change.
//   LOCKED: bad edge -> UNLOCKED, lock_lost pulse, err_count++.
//  Timeout: cnt reaches TIMEOUT with no edge ->
//   clk_missing <= 1, state <= UNLOCKED, good_cnt <= 0.
//   If the state was LOCKED, also pulse lock_lost and increment err_count.
//   clk_missing clears on the next edge; that edge is treated as an UNLOCKED first edge.
//  err_count saturates at 16'hFFFF. It is cleared only by reset.
//  en low: state UNLOCKED, good_cnt 0, locked 0.
//   Strobes, synchronizer, cnt and half_period keep running. No lock_lost or err_count change.
//   Rising en is handled like a fresh start: the next edge is an UNLOCKED first edge.
//  Simultaneous edge and timeout: the edge wins (cnt reloads, no timeout).
//  Reset mid-operation clears everything immediately (async). The first post-reset edge may be spurious.
// TESTING
//  1. div-10 clk_in, en=1 -> half_period=5, strobes alternate every 5 cycles, locked after 1+8 edges.
//  2. Locked, one half-period of 6 and then one of 4 -> stays locked. One half-period of 7 -> lock_lost pulse, err_count=1.
//  3. Locked, clk_in frozen -> clk_missing=1 and lock_lost 20 cycles after the last edge. Restart -> relock after 9 edges.
//  4. Reset asserted while locked with err_count=3 -> all outputs 0 asynchronously. Relock after release.
//  5. Deassert en while locked -> locked=0, no lock_lost, err_count unchanged. Reassert -> relock after 9 edges.
//  6. div-12 clk_in (half-period 6) stays locked. div-14 (7) never locks, half_period=7.

Source files
------------

// File: rtl/clk_26_monitor_if.sv
// clk_26_monitor_if
//   Bundles the monitored clock, the enable and every status output of
//   clk_26_monitor.
//   master : the side that drives clk_in/en and consumes status (system/bench)
//   slave  : the monitor itself
//   Signals: clk_in, en (to monitor); rise_strobe, fall_strobe, half_period,
//            locked, lock_lost, clk_missing, err_count (from monitor).
interface clk_26_monitor_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             clk_in;
  logic             en;
  logic             rise_strobe;
  logic             fall_strobe;
  logic [CNT_W-1:0] half_period;
  logic             locked;
  logic             lock_lost;
  logic             clk_missing;
  logic [15:0]      err_count;

  modport master (
    output clk_in, en,
    input  rise_strobe, fall_strobe, half_period, locked, lock_lost,
           clk_missing, err_count
  );

  modport slave (
    input  clk_in, en,
    output rise_strobe, fall_strobe, half_period, locked, lock_lost,
           clk_missing, err_count
  );
endinterface

// File: rtl/clk_26_monitor.sv
// clk_26_monitor
//   Receive-side checker for the divided pixel clock (nominally ref_clock/10).
//   Synchronises clk_in, emits registered rise/fall strobes, measures every
//   half-period in ref_clock cycles, tracks frequency lock and flags a
//   stopped clock.
//   Ports:
//     ref_clock : reference clock
//     reset     : asynchronous, active-high
//     mon       : slave side of clk_26_monitor_if (clk_in, en in; strobes,
//                 half_period, locked, lock_lost, clk_missing, err_count out)
module clk_26_monitor #(
  parameter int unsigned DIV_HALF   = 5,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned TIMEOUT    = 20,
  parameter int unsigned CNT_W      = 8
) (
  input  logic            ref_clock,
  input  logic            reset,
  clk_26_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Lower bound clamps at zero so a large TOL cannot wrap around.
  localparam logic [CNT_W-1:0] LO_LIM  = (DIV_HALF > TOL) ? CNT_W'(DIV_HALF - TOL) : '0;
  localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(DIV_HALF + TOL);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    LOCK_M1 = GW'(LOCK_COUNT - 1);

  // ---------------------------------------------------------------------
  // Input path: two-flop synchroniser followed by a history flop
  // ---------------------------------------------------------------------
  logic sync1_q, sync2_q, hist_q;
  logic edge_det;

  always_ff @(posedge ref_clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= mon.clk_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_det = sync2_q ^ hist_q;

  // ---------------------------------------------------------------------
  // Half-period counter and measurement
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] hp_q;
  logic             rise_q, fall_q;
  logic             good, timeout;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign cnt_d   = edge_det ? CNT_W'(1) : cnt_inc;
  // cnt_q is the measurement on an edge cycle (value before reload).
  assign good    = (cnt_q >= LO_LIM) && (cnt_q <= HI_LIM);
  // Fires once, on the cycle cnt steps onto TIMEOUT; an edge in the same
  // cycle wins. The != term keeps a saturated counter from re-firing.
  assign timeout = !edge_det && (cnt_inc == TO_VAL) && (cnt_q != TO_VAL);

  always_ff @(posedge ref_clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      hp_q   <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rise_q <= edge_det &&  sync2_q;
      fall_q <= edge_det && !sync2_q;
      if (edge_det) hp_q <= cnt_q;
    end
  end

  // ---------------------------------------------------------------------
  // Lock FSM with registered status outputs
  // ---------------------------------------------------------------------
  state_t        state_q;
  logic [GW-1:0] gcnt_q;
  logic          locked_q, lost_q, miss_q;
  logic [15:0]   err_q, err_inc;

  assign err_inc = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

  always_ff @(posedge ref_clock or posedge reset) begin
    if (reset) begin
      state_q  <= UNLOCKED;
      gcnt_q   <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      miss_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      lost_q <= 1'b0;

      // Missing-clock flag follows the counter regardless of en.
      if (edge_det)     miss_q <= 1'b0;
      else if (timeout) miss_q <= 1'b1;

      if (!mon.en) begin
        // Held in UNLOCKED, so re-enabling starts from a fresh first edge.
        state_q  <= UNLOCKED;
        gcnt_q   <= '0;
        locked_q <= 1'b0;
      end else if (edge_det) begin
        unique case (state_q)
          UNLOCKED: begin
            // First edge has an unknown reference point; discard it.
            state_q <= ACQUIRE;
            gcnt_q  <= '0;
          end
          ACQUIRE: begin
            if (good) begin
              gcnt_q <= gcnt_q + 1'b1;
              if (gcnt_q == LOCK_M1) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              gcnt_q <= '0;
            end
          end
          LOCKED: begin
            if (!good) begin
              state_q  <= UNLOCKED;
              gcnt_q   <= '0;
              locked_q <= 1'b0;
              lost_q   <= 1'b1;
              err_q    <= err_inc;
            end
          end
          default: begin
            state_q  <= UNLOCKED;
            gcnt_q   <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end else if (timeout) begin
        state_q  <= UNLOCKED;
        gcnt_q   <= '0;
        locked_q <= 1'b0;
        if (state_q == LOCKED) begin
          lost_q <= 1'b1;
          err_q  <= err_inc;
        end
      end
    end
  end

  assign mon.rise_strobe = rise_q;
  assign mon.fall_strobe = fall_q;
  assign mon.half_period = hp_q;
  assign mon.locked      = locked_q;
  assign mon.lock_lost   = lost_q;
  assign mon.clk_missing = miss_q;
  assign mon.err_count   = err_q;

endmodule

// File: tb/tb_clk_26_monitor.sv
// tb_clk_26_monitor
//   Drives clk_in from a programmable half-period generator and compares all
//   monitor outputs every cycle against a behavioural model, plus directed
//   end-of-scenario checks.
module tb_clk_26_monitor;
  localparam int DIV_HALF = 5;
  localparam int TOL      = 1;
  localparam int LOCKN    = 8;
  localparam int TOUT     = 20;

  logic ref_clock = 1'b0;
  logic reset     = 1'b1;
  logic gclk_in   = 1'b0;
  logic en_r      = 1'b0;

  always #5 ref_clock = ~ref_clock;

  clk_26_monitor_if #(.CNT_W(8)) bus ();
  assign bus.clk_in = gclk_in;
  assign bus.en     = en_r;

  clk_26_monitor #(
    .DIV_HALF(DIV_HALF), .TOL(TOL), .LOCK_COUNT(LOCKN), .TIMEOUT(TOUT), .CNT_W(8)
  ) dut (
    .ref_clock(ref_clock),
    .reset    (reset),
    .mon      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clk_in generator ----------------
  bit gen_run  = 1'b0;
  bit gen_rand = 1'b0;
  int gen_half = 5;
  int cur_half = 5;
  int gen_cnt  = 0;
  int jq[$];

  always @(negedge ref_clock) begin
    if (gen_run) begin
      gen_cnt++;
      if (gen_cnt >= cur_half) begin
        gclk_in = ~gclk_in;
        gen_cnt = 0;
        if (jq.size() > 0)  cur_half = jq.pop_front();
        else if (gen_rand)  cur_half = ($urandom_range(0, 15) < 12) ? int'($urandom_range(4, 6))
                                                                   : int'($urandom_range(2, 9));
        else                cur_half = gen_half;
      end
    end
  end

  // ---------------- reference model ----------------
  // Edges are seen three ref_clock cycles after clk_in changes; the model
  // keeps the last three samples and judges each edge by the time elapsed
  // since the previous one.
  bit          dly[$];
  int          age;
  bit          m_lk, m_first;
  int          m_streak;
  bit          ev, rv, good, to;
  int          meas;
  logic        e_rise, e_fall, e_lost, e_miss, e_lk;
  logic [7:0]  e_hp;
  logic [15:0] e_err;

  always @(posedge ref_clock or posedge reset) begin
    if (reset) begin
      dly = {};
      dly.push_back(1'b0); dly.push_back(1'b0); dly.push_back(1'b0);
      age = 0; m_lk = 0; m_first = 1; m_streak = 0;
      e_rise = 0; e_fall = 0; e_lost = 0; e_miss = 0; e_lk = 0;
      e_hp = 8'd0; e_err = 16'd0;
    end else begin
      ev = (dly[0] != dly[1]);
      rv = dly[1];
      e_rise = ev && rv;
      e_fall = ev && !rv;
      e_lost = 0;
      meas = age;
      if (ev) begin
        e_hp = 8'(meas);
        age  = 1;
      end else if (age < 255) begin
        age++;
      end
      to   = !ev && (age == TOUT);
      good = ((meas > DIV_HALF) ? meas - DIV_HALF : DIV_HALF - meas) <= TOL;
      if (ev)      e_miss = 0;
      else if (to) e_miss = 1;
      if (!bus.en) begin
        m_lk = 0; m_first = 1; m_streak = 0;
      end else if (ev) begin
        if (m_lk) begin
          if (!good) begin
            m_lk = 0; m_first = 1; m_streak = 0; e_lost = 1;
            if (e_err != 16'hFFFF) e_err++;
          end
        end else if (m_first) begin
          m_first = 0; m_streak = 0;
        end else if (good) begin
          m_streak++;
          if (m_streak == LOCKN) m_lk = 1;
        end else begin
          m_streak = 0;
        end
      end else if (to) begin
        if (m_lk) begin
          e_lost = 1;
          if (e_err != 16'hFFFF) e_err++;
        end
        m_lk = 0; m_first = 1; m_streak = 0;
      end
      e_lk = m_lk;
      dly.push_back(bus.clk_in);
      void'(dly.pop_front());
    end
  end

  logic [28:0] obs, expv;
  assign obs  = {bus.rise_strobe, bus.fall_strobe, bus.half_period, bus.locked,
                 bus.lock_lost, bus.clk_missing, bus.err_count};
  assign expv = {e_rise, e_fall, e_hp, e_lk, e_lost, e_miss, e_err};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge ref_clock);
    n_cmp++;
    if (obs !== 29'd0) begin n_bad++; $display("FAIL reset_state: dut=%h want=0", obs); end
    #3 reset = 1'b0;
    en_r = 1'b1;
    repeat (25) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL reset_run t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    n_cmp++;
    if (bus.clk_missing !== 1'b1) begin n_bad++; $display("FAIL reset_missing: dut=%b want=1", bus.clk_missing); end
  endtask

  task automatic test_lock();
    gen_half = 5; gen_run = 1'b1;
    repeat (120) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL lock t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    n_cmp++;
    if (bus.half_period !== 8'd5 || bus.locked !== 1'b1)
      begin n_bad++; $display("FAIL lock_final: hp=%0d locked=%b want 5/1", bus.half_period, bus.locked); end
  endtask

  task automatic test_jitter();
    jq.push_back(6); jq.push_back(4);
    repeat (40) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL jitter_ok t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    n_cmp++;
    if (bus.locked !== 1'b1 || bus.err_count !== 16'd0)
      begin n_bad++; $display("FAIL jitter_keep: locked=%b err=%0d want 1/0", bus.locked, bus.err_count); end
    jq.push_back(7);
    repeat (30) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL jitter_bad t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    n_cmp++;
    if (bus.err_count !== 16'd1) begin n_bad++; $display("FAIL jitter_err: dut=%0d want 1", bus.err_count); end
    repeat (100) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL jitter_relock t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
  endtask

  task automatic test_timeout();
    gen_run = 1'b0;
    repeat (30) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL timeout t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    n_cmp++;
    if (bus.clk_missing !== 1'b1 || bus.locked !== 1'b0 || bus.err_count !== 16'd2)
      begin n_bad++; $display("FAIL timeout_state: miss=%b locked=%b err=%0d want 1/0/2", bus.clk_missing, bus.locked, bus.err_count); end
    gen_run = 1'b1;
    repeat (100) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL timeout_relock t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    n_cmp++;
    if (bus.locked !== 1'b1 || bus.clk_missing !== 1'b0)
      begin n_bad++; $display("FAIL timeout_restart: locked=%b miss=%b want 1/0", bus.locked, bus.clk_missing); end
  endtask

  task automatic test_bad_edge();
    jq.push_back(8);
    repeat (130) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL bad_edge t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    n_cmp++;
    if (bus.err_count !== 16'd3 || bus.locked !== 1'b1)
      begin n_bad++; $display("FAIL bad_edge_final: err=%0d locked=%b want 3/1", bus.err_count, bus.locked); end
  endtask

  task automatic test_enable();
    @(negedge ref_clock); en_r = 1'b0;
    repeat (20) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL en_low t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    n_cmp++;
    if (bus.locked !== 1'b0 || bus.err_count !== 16'd3 || bus.half_period !== 8'd5)
      begin n_bad++; $display("FAIL en_low_state: locked=%b err=%0d hp=%0d want 0/3/5", bus.locked, bus.err_count, bus.half_period); end
    en_r = 1'b1;
    repeat (100) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL en_high t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    n_cmp++;
    if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL en_relock: locked=%b want 1", bus.locked); end
  endtask

  task automatic test_async_reset();
    n_cmp++;
    if (bus.err_count !== 16'd3) begin n_bad++; $display("FAIL pre_reset_err: dut=%0d want 3", bus.err_count); end
    @(negedge ref_clock);
    #2 reset = 1'b1;
    #1 n_cmp++;
    if (obs !== 29'd0) begin n_bad++; $display("FAIL async_reset: dut=%h want 0", obs); end
    repeat (3) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL in_reset t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    #3 reset = 1'b0;
    repeat (100) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL post_reset t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    n_cmp++;
    if (bus.locked !== 1'b1 || bus.err_count !== 16'd0)
      begin n_bad++; $display("FAIL reset_relock: locked=%b err=%0d want 1/0", bus.locked, bus.err_count); end
  endtask

  task automatic test_div();
    gen_half = 6;
    repeat (150) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL div12 t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    n_cmp++;
    if (bus.locked !== 1'b1 || bus.half_period !== 8'd6)
      begin n_bad++; $display("FAIL div12_final: locked=%b hp=%0d want 1/6", bus.locked, bus.half_period); end
    gen_half = 7;
    repeat (200) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL div14 t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
    n_cmp++;
    if (bus.locked !== 1'b0 || bus.half_period !== 8'd7 || bus.err_count !== 16'd1)
      begin n_bad++; $display("FAIL div14_final: locked=%b hp=%0d err=%0d want 0/7/1", bus.locked, bus.half_period, bus.err_count); end
  endtask

  task automatic test_random();
    int r;
    gen_rand = 1'b1; gen_half = 5;
    repeat (800) begin
      @(negedge ref_clock);
      n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL random t=%0t: dut=%h model=%h", $time, obs, expv); end
      r = int'($urandom_range(0, 255));
      if (r < 3)       en_r    = ~en_r;
      else if (r < 5)  gen_run = ~gen_run;
    end
    gen_rand = 1'b0; gen_run = 1'b1; en_r = 1'b1;
    repeat (20) begin
      @(negedge ref_clock); n_cmp++;
      if (obs !== expv) begin n_bad++; if (n_bad < 30) $display("FAIL random_tail t=%0t: dut=%h model=%h", $time, obs, expv); end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_jitter();
    test_timeout();
    test_bad_edge();
    test_enable();
    test_async_reset();
    test_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
